// File: rtl/cpu_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp with a prescaled tick,
// a coherent LO/HI read shadow and a one-shot timer-interrupt pulse.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a request; the access is performed on leaving
// ACK      | o_ready high for this single cycle
// WAIT_REL | waiting for the master to drop i_request
module cpu_timer #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [4:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_interrupt
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACK      = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  localparam logic [2:0] REG_MTIME_LO = 3'd0;
  localparam logic [2:0] REG_MTIME_HI = 3'd1;
  localparam logic [2:0] REG_CMP_LO   = 3'd2;
  localparam logic [2:0] REG_CMP_HI   = 3'd3;
  localparam logic [2:0] REG_CTRL     = 3'd4;

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [1:0]  state;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [15:0] prescaler;
  logic        enable;
  logic        armed;
  logic [31:0] hi_shadow;

  logic        access;
  logic        rd_access;
  logic        wr_access;
  logic [2:0]  sel;
  logic        mtime_wr;
  logic        cmp_wr;
  logic        fire;
  logic [31:0] rdata_next;
  logic        unused_addr_bits;

  assign sel              = i_address[4:2];
  assign unused_addr_bits = ^i_address[1:0];

  assign access    = (state == ST_IDLE) && i_request;
  assign rd_access = access && !i_rw;
  assign wr_access = access && i_rw;
  assign mtime_wr  = wr_access && ((sel == REG_MTIME_LO) || (sel == REG_MTIME_HI));
  assign cmp_wr    = wr_access && ((sel == REG_CMP_LO) || (sel == REG_CMP_HI));
  assign fire      = armed && (mtime >= mtimecmp);

  always_comb begin
    rdata_next = '0;
    case (sel)
      REG_MTIME_LO: rdata_next = mtime[31:0];
      REG_MTIME_HI: rdata_next = hi_shadow;
      REG_CMP_LO:   rdata_next = mtimecmp[31:0];
      REG_CMP_HI:   rdata_next = mtimecmp[63:32];
      REG_CTRL:     rdata_next = {31'b0, enable};
      default:      rdata_next = '0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      o_ready   <= 1'b0;
      o_rdata   <= '0;
      hi_shadow <= '0;
    end else begin
      case (state)
        ST_IDLE:     if (i_request) state <= ST_ACK;
        ST_ACK:      state <= ST_WAIT_REL;
        ST_WAIT_REL: if (!i_request) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
      o_ready <= access;
      if (rd_access) begin
        o_rdata <= rdata_next;
        // Freeze the upper half so a following HI read matches this LO read.
        if (sel == REG_MTIME_LO) hi_shadow <= mtime[63:32];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      mtime       <= '0;
      mtimecmp    <= '1;
      prescaler   <= '0;
      enable      <= 1'b1;
      armed       <= 1'b0;
      o_interrupt <= 1'b0;
    end else begin
      // A software write to mtime wins over the tick that would land this cycle.
      if (mtime_wr) begin
        prescaler <= '0;
        if (sel == REG_MTIME_LO) mtime[31:0]  <= i_wdata;
        else                     mtime[63:32] <= i_wdata;
      end else if (enable) begin
        if (prescaler == PRE_LAST) begin
          prescaler <= '0;
          mtime     <= mtime + 64'd1;
        end else begin
          prescaler <= prescaler + 16'd1;
        end
      end

      if (wr_access && (sel == REG_CTRL)) enable <= i_wdata[0];

      if (cmp_wr) begin
        if (sel == REG_CMP_LO) mtimecmp[31:0]  <= i_wdata;
        else                   mtimecmp[63:32] <= i_wdata;
      end

      // One pulse per compare write: the CSR unit re-latches MTIP on every high cycle.
      o_interrupt <= fire;
      if (cmp_wr)    armed <= 1'b1;
      else if (fire) armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_timer.sv
// Self-checking bench for cpu_timer: directed vectors, multi-cycle corner
// sequences and random bus traffic against an arithmetic timer model.
module tb_cpu_timer;

  localparam int P = 4;

  logic        i_clock;
  logic        i_reset;
  logic        i_request;
  logic        i_rw;
  logic [4:0]  i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_interrupt;

  cpu_timer #(.PRESCALE(P)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_request   (i_request),
    .i_rw        (i_rw),
    .i_address   (i_address),
    .i_wdata     (i_wdata),
    .o_rdata     (o_rdata),
    .o_ready     (o_ready),
    .o_interrupt (o_interrupt)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: mtime after edge n is derived from the last point it was
  // established (write, reset or enable change) plus elapsed enabled edges / P.
  logic [63:0] m_base;
  int          m_base_edge;
  int          m_pre;
  bit          m_en;
  logic [63:0] m_cmp;
  bit          m_armed;
  logic [31:0] m_shadow;

  int          cyc = 0;
  bit          pend_valid = 1'b0;
  logic        pend_rw;
  logic [4:0]  pend_addr;
  logic [31:0] pend_wd;
  logic [31:0] exp_rdata = '0;
  logic        exp_int = 1'b0;
  int          int_count = 0;
  int          last_int_edge = -1;

  function automatic logic [63:0] mt(input int n);
    if (m_en) return m_base + 64'((m_pre + n - m_base_edge) / P);
    return m_base;
  endfunction

  function automatic int pre_at(input int n);
    if (m_en) return (m_pre + n - m_base_edge) % P;
    return m_pre;
  endfunction

  task automatic model_reset(input int n);
    m_base = '0; m_base_edge = n; m_pre = 0; m_en = 1'b1;
    m_cmp = '1; m_armed = 1'b0; m_shadow = '0;
    exp_int = 1'b0; pend_valid = 1'b0;
  endtask

  task automatic model_step(input int n);
    logic [63:0] mcur;
    logic [63:0] mnext;
    int          pnext;
    mcur = mt(n - 1);
    exp_int = m_armed && (mcur >= m_cmp);
    if (exp_int) m_armed = 1'b0;
    if (pend_valid) begin
      pend_valid = 1'b0;
      if (!pend_rw) begin
        case (pend_addr[4:2])
          3'd0: begin exp_rdata = mcur[31:0]; m_shadow = mcur[63:32]; end
          3'd1: exp_rdata = m_shadow;
          3'd2: exp_rdata = m_cmp[31:0];
          3'd3: exp_rdata = m_cmp[63:32];
          3'd4: exp_rdata = {31'b0, m_en};
          default: exp_rdata = '0;
        endcase
      end else begin
        case (pend_addr[4:2])
          3'd0: begin m_base = {mcur[63:32], pend_wd}; m_pre = 0; m_base_edge = n; end
          3'd1: begin m_base = {pend_wd, mcur[31:0]}; m_pre = 0; m_base_edge = n; end
          3'd2: begin m_cmp[31:0] = pend_wd; m_armed = 1'b1; end
          3'd3: begin m_cmp[63:32] = pend_wd; m_armed = 1'b1; end
          3'd4: begin
            mnext = mt(n); pnext = pre_at(n);
            m_base = mnext; m_pre = pnext; m_base_edge = n; m_en = pend_wd[0];
          end
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge i_clock);
      cyc++;
      if (i_reset) model_reset(cyc);
      else model_step(cyc);
      #1;
      check("irq_pulse", o_interrupt, exp_int);
      if (o_interrupt === 1'b1) begin
        int_count++;
        last_int_edge = cyc;
      end
    end
  end

  task automatic bus(input logic rw, input logic [4:0] addr, input logic [31:0] wd, input int gap,
                     input bit use_exp, input logic [31:0] exp, input string name, output int edge_n);
    repeat (gap) @(posedge i_clock);
    @(negedge i_clock);
    i_request = 1'b1; i_rw = rw; i_address = addr; i_wdata = wd;
    pend_rw = rw; pend_addr = addr; pend_wd = wd; pend_valid = 1'b1;
    @(posedge i_clock); #1;
    edge_n = cyc;
    check({name, "_ready"}, o_ready, 1);
    if (!rw) check(name, o_rdata, use_exp ? exp : exp_rdata);
    i_request = 1'b0;
    @(posedge i_clock); #1;
    check({name, "_ready_drop"}, o_ready, 0);
    @(posedge i_clock);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input int gap, output int e);
    bus(1'b1, a, d, gap, 1'b0, 32'h0, "wr", e);
  endtask

  task automatic rdc(input logic [4:0] a, input logic [31:0] x, input int gap, input string nm);
    int e;
    bus(1'b0, a, 32'h0, gap, 1'b1, x, nm, e);
  endtask

  task automatic rdm(input logic [4:0] a, input int gap, input string nm);
    int e;
    bus(1'b0, a, 32'h0, gap, 1'b0, 32'h0, nm, e);
  endtask

  typedef struct {
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int e, w, f, g, b, c0, rdy_cnt, gap, op;
    logic [63:0] cur;

    tbl[0]  = '{1'b1, 5'h08, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b0, 5'h08, 32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 5'h0C, 32'h1234_5678, 32'h0};
    tbl[3]  = '{1'b0, 5'h0C, 32'h0,         32'h1234_5678};
    tbl[4]  = '{1'b1, 5'h04, 32'h0000_00A5, 32'h0};
    tbl[5]  = '{1'b0, 5'h00, 32'h0,         32'h0000_03E8};
    tbl[6]  = '{1'b0, 5'h04, 32'h0,         32'h0000_00A5};
    tbl[7]  = '{1'b1, 5'h14, 32'hFFFF_FFFF, 32'h0};
    tbl[8]  = '{1'b0, 5'h14, 32'h0,         32'h0};
    tbl[9]  = '{1'b0, 5'h1C, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 5'h10, 32'h0,         32'h0};
    tbl[11] = '{1'b0, 5'h03, 32'h0,         32'h0000_03E8};
    tbl[12] = '{1'b0, 5'h13, 32'h0,         32'h0};

    i_reset = 1'b1; i_request = 1'b0; i_rw = 1'b0; i_address = '0; i_wdata = '0;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    check("reset_ready", o_ready, 0);
    check("reset_rdata", o_rdata, 0);
    check("reset_irq", o_interrupt, 0);
    i_reset = 1'b0;

    // Prescale count
    repeat (40) @(posedge i_clock);
    rdc(5'h00, 32'd10, 0, "prescale_lo");
    rdc(5'h04, 32'd0, 0, "prescale_hi");

    // Coherent carry across the 32-bit boundary
    wr(5'h04, 32'h0, 0, e);
    wr(5'h00, 32'hFFFF_FFFF, 0, e);
    rdc(5'h00, 32'hFFFF_FFFF, 0, "carry_lo");
    repeat (8) @(posedge i_clock);
    rdc(5'h04, 32'h0, 0, "carry_shadow_hi");
    rdm(5'h00, 0, "carry_lo2");
    rdc(5'h04, 32'h1, 0, "carry_hi");

    // Interrupt fires once, then again on compare rewrite
    wr(5'h04, 32'h0, 0, e);
    wr(5'h00, 32'h0, 0, w);
    wr(5'h0C, 32'h0, 0, e);
    wr(5'h08, 32'd5, 0, e);
    c0 = int_count;
    repeat (130) @(posedge i_clock);
    #2;
    check("irq_once", int_count, c0 + 1);
    check("irq_edge", last_int_edge, w + 5 * P + 1);
    wr(5'h08, 32'd5, 0, f);
    repeat (3) @(posedge i_clock);
    #2;
    check("irq_rearm_edge", last_int_edge, f + 1);
    check("irq_rearm_count", int_count, c0 + 2);

    // Past compare with the counter stopped
    wr(5'h10, 32'h0, 0, e);
    wr(5'h04, 32'h0, 0, e);
    wr(5'h00, 32'd1000, 0, e);
    wr(5'h08, 32'd10, 0, g);
    repeat (3) @(posedge i_clock);
    #2;
    check("irq_past_edge", last_int_edge, g + 1);
    rdc(5'h00, 32'd1000, 0, "stopped_lo");

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rw) wr(tbl[i].addr, tbl[i].wdata, 0, e);
      else rdc(tbl[i].addr, tbl[i].exp, 0, $sformatf("tbl%0d", i));
    end

    // Write landing on the prescaler wrap edge
    wr(5'h10, 32'h1, 0, e);
    wr(5'h00, 32'h0, 0, b);
    wr(5'h00, 32'd7, 1, e);
    check("collide_edge", e, b + P);
    rdc(5'h00, 32'd7, 1, "collide_hold");
    rdc(5'h00, 32'd8, 1, "collide_next");

    // Request held for 10 cycles is serviced once
    @(negedge i_clock);
    i_request = 1'b1; i_rw = 1'b0; i_address = 5'h10;
    pend_rw = 1'b0; pend_addr = 5'h10; pend_wd = '0; pend_valid = 1'b1;
    rdy_cnt = 0;
    repeat (10) begin
      @(posedge i_clock); #1;
      if (o_ready === 1'b1) rdy_cnt++;
    end
    i_request = 1'b0;
    check("held_ready_count", rdy_cnt, 1);
    @(posedge i_clock);

    // Reset in the ACK cycle with the request still held
    @(negedge i_clock);
    i_request = 1'b1; i_rw = 1'b0; i_address = 5'h08;
    pend_rw = 1'b0; pend_addr = 5'h08; pend_wd = '0; pend_valid = 1'b1;
    @(posedge i_clock); #1;
    check("rst_pre_ready", o_ready, 1);
    check("rst_pre_rdata", o_rdata, 32'hDEAD_BEEF);
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    check("rst_ack_ready", o_ready, 0);
    check("rst_ack_rdata", o_rdata, 0);
    @(negedge i_clock);
    i_reset = 1'b0;
    pend_rw = 1'b0; pend_addr = 5'h08; pend_wd = '0; pend_valid = 1'b1;
    @(posedge i_clock); #1;
    check("rst_new_ready", o_ready, 1);
    check("rst_new_rdata", o_rdata, 32'hFFFF_FFFF);
    i_request = 1'b0;
    @(posedge i_clock);
    @(posedge i_clock);
    rdc(5'h10, 32'h1, 0, "rst_ctrl");
    rdc(5'h0C, 32'hFFFF_FFFF, 0, "rst_cmp_hi");
    rdc(5'h04, 32'h0, 0, "rst_shadow");
    rdc(5'h18, 32'h0, 0, "rst_unmapped");

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      gap = int'($urandom_range(0, 5));
      op  = int'($urandom_range(0, 9));
      cur = mt(cyc);
      case (op)
        0, 1, 2, 3: rdm(5'($urandom_range(0, 31)), gap, "rnd_rd");
        4: wr(5'h00, ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                 : 32'($urandom_range(0, 100)), gap, e);
        5: wr(5'h04, 32'($urandom_range(0, 2)), gap, e);
        6: wr(5'h08, cur[31:0] + 32'($urandom_range(0, 60)), gap, e);
        7: wr(5'h0C, cur[63:32] + 32'($urandom_range(0, 1)), gap, e);
        8: wr(5'h10, {31'b0, ($urandom_range(0, 3) != 0)}, gap, e);
        default: wr(5'($urandom_range(20, 31)), $urandom, gap, e);
      endcase
    end

    repeat (5) @(posedge i_clock);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
